// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared definitions for the LDPC LLR packer.
//   ldpc_state_e : packer control states (ST_INIT after reset, ST_RUN after).
//   llr_max()    : largest magnitude a symmetric LLR of the given width may take;
//                  the saturation range is [-llr_max, +llr_max], so the
//                  most-negative two's-complement code is never produced.
package ldpc_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ldpc_state_e;

    function automatic int llr_max(input int llr_width);
        return (1 << (llr_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/ldpc_llr_quant.sv
// ldpc_llr_quant: combinational soft-sample to LLR quantizer.
//   sample : signed soft sample, IN_WIDTH bits
//   shift  : arithmetic right-shift amount (rounds toward negative infinity)
//   llr    : shifted sample saturated to the symmetric LLR_WIDTH range
module ldpc_llr_quant
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int LLR_WIDTH = 6
) (
    input  logic [IN_WIDTH-1:0]  sample,
    input  logic [3:0]           shift,
    output logic [LLR_WIDTH-1:0] llr
);

    localparam logic signed [IN_WIDTH-1:0] LLR_HI = IN_WIDTH'(llr_max(LLR_WIDTH));
    localparam logic signed [IN_WIDTH-1:0] LLR_LO = IN_WIDTH'(-llr_max(LLR_WIDTH));

    logic signed [IN_WIDTH-1:0] shifted;

    always_comb begin
        shifted = $signed(sample) >>> shift;
        if (shifted > LLR_HI)
            llr = LLR_HI[LLR_WIDTH-1:0];
        else if (shifted < LLR_LO)
            llr = LLR_LO[LLR_WIDTH-1:0];
        else
            llr = shifted[LLR_WIDTH-1:0];
    end

endmodule

// File: rtl/ldpc_llr_packer.sv
// ldpc_llr_packer: quantizes demapper soft samples into LLRs and packs LANES
// of them per output word for the downstream FIFO.
//   i_clock / i_reset            : clock, synchronous active-high reset
//   i_in_sample/valid/last       : sample stream; last marks codeword end
//   o_in_ready                   : sample accepted when high with i_in_valid
//   i_shift                      : quantizer shift, latched per codeword
//   o_out_data/valid/last        : packed word stream, lane 0 in the LSBs
//   i_out_ready                  : downstream accept
//   o_frame_err                  : sticky, i_in_last disagreed with the count
module ldpc_llr_packer
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH     = 16,
    parameter int LLR_WIDTH    = 6,
    parameter int LANES        = 8,
    parameter int CODEWORD_LEN = 648
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [IN_WIDTH-1:0]        i_in_sample,
    input  logic                       i_in_valid,
    input  logic                       i_in_last,
    output logic                       o_in_ready,
    input  logic [3:0]                 i_shift,
    output logic [LANES*LLR_WIDTH-1:0] o_out_data,
    output logic                       o_out_valid,
    output logic                       o_out_last,
    input  logic                       i_out_ready,
    output logic                       o_frame_err
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = (CODEWORD_LEN > 1) ? $clog2(CODEWORD_LEN) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CODEWORD_LEN - 1);

    ldpc_state_e state;

    logic [LANE_W-1:0] lane_idx;
    logic [CNT_W-1:0]  sample_cnt;
    logic [3:0]        shift_q;
    logic [3:0]        eff_shift;
    logic [LLR_WIDTH-1:0] llr;

    logic [LANES-1:0][LLR_WIDTH-1:0] pack_q;
    logic [LANES-1:0][LLR_WIDTH-1:0] pack_next;
    logic [LANES-1:0][LLR_WIDTH-1:0] out_q;
    logic out_valid_q;
    logic out_last_q;
    logic frame_err_q;

    logic cw_end;
    logic word_done;
    logic out_busy;
    logic in_ready;
    logic accept;

    // The first sample of a codeword uses the live shift input; the rest of
    // the codeword uses the copy latched alongside that first sample.
    assign eff_shift = (sample_cnt == '0) ? i_shift : shift_q;

    ldpc_llr_quant #(
        .IN_WIDTH  (IN_WIDTH),
        .LLR_WIDTH (LLR_WIDTH)
    ) u_quant (
        .sample (i_in_sample),
        .shift  (eff_shift),
        .llr    (llr)
    );

    assign cw_end    = i_in_last || (sample_cnt == CNT_LAST);
    assign word_done = (lane_idx == LANE_LAST) || cw_end;
    assign out_busy  = out_valid_q && !i_out_ready;

    // Only a word-completing sample needs the output register, so input is
    // stalled just for that sample; a draining register may be reloaded in
    // the same cycle.
    assign in_ready = (state == ST_RUN) && !i_reset && !(word_done && out_busy);
    assign accept   = in_ready && i_in_valid;

    // pack_q lanes above lane_idx are always zero (cleared on every word), so
    // a word closed early by codeword end is already erasure-padded.
    always_comb begin
        pack_next           = pack_q;
        pack_next[lane_idx] = llr;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_INIT;
            lane_idx    <= '0;
            sample_cnt  <= '0;
            shift_q     <= '0;
            pack_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state <= ST_RUN;

            if (accept) begin
                if (sample_cnt == '0)
                    shift_q <= i_shift;
                if (word_done) begin
                    pack_q   <= '0;
                    lane_idx <= '0;
                end else begin
                    pack_q   <= pack_next;
                    lane_idx <= lane_idx + 1'b1;
                end
                sample_cnt <= cw_end ? '0 : sample_cnt + 1'b1;
                // Marker and count must agree; either one alone is a framing slip.
                if (cw_end && (i_in_last != (sample_cnt == CNT_LAST)))
                    frame_err_q <= 1'b1;
            end

            if (accept && word_done) begin
                out_q       <= pack_next;
                out_valid_q <= 1'b1;
                out_last_q  <= cw_end;
            end else if (i_out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Outputs are forced quiet while reset is held so a pending word cannot
    // be taken by the FIFO during the reset cycle.
    assign o_in_ready  = in_ready;
    assign o_out_data  = out_q;
    assign o_out_valid = out_valid_q && (state == ST_RUN) && !i_reset;
    assign o_out_last  = out_last_q && o_out_valid;
    assign o_frame_err = frame_err_q && !i_reset;

endmodule

// File: tb/tb_ldpc_llr_packer.sv
// tb_ldpc_llr_packer: directed, scoreboarded bench for ldpc_llr_packer.
// Instance a uses CODEWORD_LEN=648, instance b CODEWORD_LEN=650; both share
// the stimulus and tgt selects which one the scoreboard follows.
module tb_ldpc_llr_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample;
    logic        valid, last, out_ready;
    logic [3:0]  shift;

    logic        rdy_a, vld_a, lst_a, err_a;
    logic [47:0] data_a;
    logic        rdy_b, vld_b, lst_b, err_b;
    logic [47:0] data_b;

    always #5 clk = ~clk;

    ldpc_llr_packer #(.CODEWORD_LEN(648)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_in_sample(sample), .i_in_valid(valid),
        .i_in_last(last), .o_in_ready(rdy_a), .i_shift(shift), .o_out_data(data_a),
        .o_out_valid(vld_a), .o_out_last(lst_a), .i_out_ready(out_ready), .o_frame_err(err_a)
    );

    ldpc_llr_packer #(.CODEWORD_LEN(650)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_in_sample(sample), .i_in_valid(valid),
        .i_in_last(last), .o_in_ready(rdy_b), .i_shift(shift), .o_out_data(data_b),
        .o_out_valid(vld_b), .o_out_last(lst_b), .i_out_ready(out_ready), .o_frame_err(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int tgt = 0;
    int n_words = 0;
    logic [47:0] last_word;
    logic [48:0] exp_q[$];

    // reference model state
    logic [47:0] mbuf;
    int mlane, mcnt, mlen, mshift;

    logic rdy_t;
    assign rdy_t = (tgt == 1) ? rdy_b : rdy_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [5:0] mq(input logic [15:0] s, input int sh);
        int v;
        v = $signed(s);
        v = v >>> sh;
        if (v > 31) v = 31;
        if (v < -31) v = -31;
        return v[5:0];
    endfunction

    task automatic m_reset(input int len);
        mbuf = '0; mlane = 0; mcnt = 0; mshift = 0; mlen = len;
        exp_q.delete();
        n_words = 0;
    endtask

    task automatic m_accept(input logic [15:0] s, input logic lst, input logic [3:0] sh);
        logic e;
        if (mcnt == 0) mshift = int'(sh);
        mbuf[mlane*6 +: 6] = mq(s, mshift);
        e = lst || (mcnt == mlen - 1);
        if (mlane == 7 || e) begin
            exp_q.push_back({e, mbuf});
            mbuf = '0;
            mlane = 0;
        end else begin
            mlane++;
        end
        mcnt = e ? 0 : mcnt + 1;
    endtask

    // Drive one sample and hold it until the target instance accepts it.
    task automatic send(input logic [15:0] s, input logic lst);
        int w = 0;
        bit acc = 0;
        logic [3:0] sh;
        sample = s; valid = 1'b1; last = lst;
        while (!acc && w < 200) begin
            @(negedge clk);
            sh = shift;
            if (rdy_t) acc = 1; else w++;
            @(posedge clk); #1;
        end
        if (acc) m_accept(s, lst, sh);
        else chk("send_timeout", 64'(w), 64'd0);
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk); w++;
        end
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n, input int len);
        rst = 1'b1; valid = 1'b0; last = 1'b0;
        m_reset(len);
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Scoreboard: every output transfer of the followed instance pops one word.
    always @(negedge clk) begin : monitor
        logic mv, ml;
        logic [47:0] md;
        logic [48:0] e;
        mv = (tgt == 1) ? vld_b : vld_a;
        ml = (tgt == 1) ? lst_b : lst_a;
        md = (tgt == 1) ? data_b : data_a;
        if (mv === 1'b1 && out_ready === 1'b1) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word", {15'd0, ml, md}, {15'd0, e});
                n_words++;
                last_word = md;
            end
        end
    end

    initial begin
        logic [47:0] held;
        logic [15:0] s16;
        longint t0;

        // ---- reset state
        rst = 1'b1; valid = 1'b0; last = 1'b0; sample = '0; shift = 4'd4; out_ready = 1'b1;
        m_reset(648);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(vld_a), 64'd0);
        chk("rst_in_ready", 64'(rdy_a), 64'd0);
        chk("rst_out_last", 64'(lst_a), 64'd0);
        chk("rst_frame_err", 64'(err_a), 64'd0);
        chk("rst_out_data", 64'(data_a), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("init_in_ready", 64'(rdy_a), 64'd0);
        chk("init_out_valid", 64'(vld_a), 64'd0);
        @(negedge clk);
        chk("run_in_ready", 64'(rdy_a), 64'd1);
        @(posedge clk); #1;

        // ---- quantization corners in the first word, then a full 648 codeword
        send(16'h7FFF, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h0025, 1'b0);
        send(16'hFFF0, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0010, 1'b0);
        send(16'hFFFF, 1'b0);
        send(16'h01F0, 1'b0);
        chk("q_pos_sat", 64'(data_a[5:0]), 64'h1F);
        chk("q_neg_sat", 64'(data_a[11:6]), 64'h21);
        chk("q_0025", 64'(data_a[17:12]), 64'h02);
        chk("q_fff0", 64'(data_a[23:18]), 64'h3F);
        for (int i = 8; i < 648; i++)
            send(16'($urandom), i == 647);
        drain();
        chk("cw648_words", 64'(n_words), 64'd81);
        chk("cw648_last_seen", 64'(lst_a), 64'd0);
        chk("cw648_frame_err", 64'(err_a), 64'd0);

        // ---- early last on sample 100; shift change mid-codeword is ignored
        shift = 4'd2;
        send(16'h0031, 1'b0);
        shift = 4'd7;
        for (int i = 1; i < 99; i++)
            send(16'($urandom), 1'b0);
        send(16'h0123, 1'b1);
        chk("early_valid", 64'(vld_a), 64'd1);
        chk("early_last", 64'(lst_a), 64'd1);
        chk("early_pad_zero", 64'(data_a[47:24]), 64'd0);
        chk("early_frame_err", 64'(err_a), 64'd1);
        for (int i = 0; i < 8; i++)
            send(16'($urandom), 1'b0);
        drain();
        chk("after_early_lane0", 64'(mlane), 64'd0);
        shift = 4'd4;

        // ---- backpressure: 10 stalled cycles, then drain+load at full rate
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++)
            send(16'($urandom), 1'b0);
        s16 = 16'($urandom);
        sample = s16; valid = 1'b1; last = 1'b0;
        @(negedge clk);
        held = data_a;
        chk("stall_word", {15'd0, lst_a, data_a}, {15'd0, exp_q[0]});
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            chk("stall_in_ready", 64'(rdy_a), 64'd0);
            chk("stall_out_valid", 64'(vld_a), 64'd1);
            chk("stall_hold", 64'(data_a), 64'(held));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(s16, 1'b0);
        t0 = $time;
        for (int i = 0; i < 16; i++)
            send(16'($urandom), 1'b0);
        chk("throughput", 64'(($time - t0) / 10), 64'd16);
        drain();

        // ---- CODEWORD_LEN=650 instance: short final word
        do_reset(2, 650);
        tgt = 1;
        for (int i = 0; i < 650; i++)
            send(16'($urandom), i == 649);
        drain();
        chk("cw650_words", 64'(n_words), 64'd82);
        chk("cw650_pad_zero", 64'(last_word[47:12]), 64'd0);
        chk("cw650_frame_err", 64'(err_b), 64'd0);

        // ---- reset mid-codeword with a pending word
        tgt = 0;
        do_reset(2, 648);
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++)
            send(16'($urandom), 1'b0);
        rst = 1'b1; out_ready = 1'b1;
        m_reset(648);
        @(negedge clk);
        chk("midrst_out_valid", 64'(vld_a), 64'd0);
        chk("midrst_in_ready", 64'(rdy_a), 64'd0);
        chk("midrst_out_last", 64'(lst_a), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 64'(vld_a), 64'd0);
        chk("postrst_in_ready", 64'(rdy_a), 64'd0);
        chk("postrst_frame_err", 64'(err_a), 64'd0);
        @(posedge clk); #1;
        send(16'h7FFF, 1'b0);
        for (int i = 1; i < 8; i++)
            send(16'($urandom), 1'b0);
        drain();
        chk("postrst_words", 64'(n_words), 64'd1);
        chk("postrst_lane0", 64'(last_word[5:0]), 64'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
